// File: rtl/mistral_m20k_pkg.sv
// Shared M20K constants: read latency, legal address/data width pairings and depth helper.
package mistral_m20k_pkg;

  localparam int M20K_RD_LATENCY = 1;

  localparam int M20K_NUM_CFG = 6;
  localparam int M20K_CFG_ABITS [M20K_NUM_CFG] = '{9, 10, 11, 12, 13, 14};
  localparam int M20K_CFG_DBITS [M20K_NUM_CFG] = '{40, 20, 10, 5, 2, 1};

  function automatic int depth_of(input int abits);
    return 1 << abits;
  endfunction

  function automatic bit is_legal_cfg(input int abits, input int dbits);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < M20K_NUM_CFG; i++) begin
      if (M20K_CFG_ABITS[i] == abits && M20K_CFG_DBITS[i] == dbits) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mistral_m20k_fifo_outq.sv
// Two-entry output queue that absorbs the RAM read latency; head word is presented on data.
module mistral_m20k_fifo_outq #(
  parameter int DBITS = 20
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             push,
  input  logic [DBITS-1:0] push_data,
  input  logic             pop,
  output logic [DBITS-1:0] data,
  output logic             valid,
  output logic [1:0]       cnt
);

  logic [DBITS-1:0] mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic             pop_ok;

  // Pop on an empty queue is meaningless; guarding here keeps count from wrapping.
  assign pop_ok = pop & (count != 2'd0);

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (pop_ok) head <= ~head;
      case ({push, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign data  = mem[head];
  assign valid = (count != 2'd0);
  assign cnt   = count;

endmodule

// File: rtl/mistral_m20k_fifo_ctrl.sv
// Streaming FIFO controller wrapped around one M20K simple-dual-port RAM.
module mistral_m20k_fifo_ctrl
  import mistral_m20k_pkg::*;
#(
  parameter int ABITS = 10,
  parameter int DBITS = 20
) (
  input  logic             CLK,
  input  logic             SCLR_N,
  input  logic [DBITS-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [DBITS-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [ABITS+1:0] LEVEL,
  output logic [ABITS-1:0] A1ADDR,
  output logic [DBITS-1:0] A1DATA,
  output logic             A1EN,
  output logic [ABITS-1:0] B1ADDR,
  output logic             B1EN,
  input  logic [DBITS-1:0] B1DATA
);

  localparam int             DEPTH      = depth_of(ABITS);
  localparam logic [ABITS:0] DEPTH_CNT  = (ABITS + 1)'(DEPTH);
  localparam int             OUTQ_SLOTS = M20K_RD_LATENCY + 1;

  logic [ABITS-1:0] wptr;
  logic [ABITS-1:0] rptr;
  logic [ABITS:0]   ram_cnt;
  logic             inflight;

  logic [DBITS-1:0] outq_data;
  logic             outq_valid;
  logic [1:0]       outq_cnt;

  logic             wr_fire;
  logic             rd_issue;
  logic             pop;
  logic [2:0]       pending;
  logic [ABITS+1:0] level_sum;

  assign IN_READY = SCLR_N & (ram_cnt < DEPTH_CNT);
  assign wr_fire  = IN_VALID & IN_READY;

  assign OUT_VALID = SCLR_N & outq_valid;
  assign OUT_DATA  = outq_data;
  assign pop       = OUT_VALID & OUT_READY;

  // Words already owed to the output queue after this cycle's pop; a read may only be
  // issued if its data is guaranteed a slot when it returns.
  assign pending  = {1'b0, outq_cnt} + {2'b00, inflight} - {2'b00, pop};

  // ram_cnt is registered, so a word written this cycle is not visible to the read
  // side until next cycle; this keeps the RAM out of same-address read-during-write.
  assign rd_issue = SCLR_N & (ram_cnt != '0) & (pending < 3'(OUTQ_SLOTS));

  assign A1EN   = wr_fire;
  assign A1ADDR = wptr;
  assign A1DATA = IN_DATA;
  assign B1EN   = rd_issue;
  assign B1ADDR = rptr;

  always_ff @(posedge CLK) begin
    if (!SCLR_N) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr_fire)  wptr <= wptr + 1'b1;
      if (rd_issue) rptr <= rptr + 1'b1;
      case ({wr_fire, rd_issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      inflight <= rd_issue;
    end
  end

  // inflight is cleared by reset, so data returning right after a reset is dropped.
  mistral_m20k_fifo_outq #(
    .DBITS (DBITS)
  ) u_outq (
    .clk       (CLK),
    .sclr_n    (SCLR_N),
    .push      (inflight),
    .push_data (B1DATA),
    .pop       (pop),
    .data      (outq_data),
    .valid     (outq_valid),
    .cnt       (outq_cnt)
  );

  assign level_sum = {1'b0, ram_cnt} + {{(ABITS+1){1'b0}}, inflight} + {{ABITS{1'b0}}, outq_cnt};
  assign LEVEL     = SCLR_N ? level_sum : '0;

endmodule

// File: tb/tb_mistral_m20k_fifo_ctrl.sv
// Scoreboard bench: behavioural M20K plus a word-queue reference of the FIFO contents.
module tb_mistral_m20k_fifo_ctrl;

  localparam int ABITS = 10;
  localparam int DBITS = 20;
  localparam int DEPTH = 1024;
  localparam int CAP   = DEPTH + 2;

  logic             CLK;
  logic             SCLR_N;
  logic [DBITS-1:0] IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic [DBITS-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [ABITS+1:0] LEVEL;
  logic [ABITS-1:0] A1ADDR;
  logic [DBITS-1:0] A1DATA;
  logic             A1EN;
  logic [ABITS-1:0] B1ADDR;
  logic             B1EN;
  logic [DBITS-1:0] B1DATA;

  mistral_m20k_fifo_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .CLK(CLK), .SCLR_N(SCLR_N), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .LEVEL(LEVEL),
    .A1ADDR(A1ADDR), .A1DATA(A1DATA), .A1EN(A1EN), .B1ADDR(B1ADDR), .B1EN(B1EN), .B1DATA(B1DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model; a same-address read-during-write returns corrupted data.
  logic [DBITS-1:0] ram [DEPTH];
  always @(posedge CLK) begin
    if (A1EN) ram[A1ADDR] <= A1DATA;
    if (B1EN) B1DATA <= (A1EN && A1ADDR == B1ADDR) ? ~ram[B1ADDR] : ram[B1ADDR];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: every accepted word in order; size is the expected LEVEL.
  logic [DBITS-1:0] model_q[$];
  int               wr_total = 0;
  int               rd_total = 0;
  bit               prev_stall = 0;
  logic [DBITS-1:0] prev_data;

  always @(negedge CLK) begin
    if (!SCLR_N) begin
      chk("rst_out_valid", 32'(OUT_VALID), 0);
      chk("rst_level", 32'(LEVEL), 0);
      chk("rst_in_ready", 32'(IN_READY), 0);
      chk("rst_a1en", 32'(A1EN), 0);
      chk("rst_b1en", 32'(B1EN), 0);
      model_q.delete();
      wr_total = 0;
      rd_total = 0;
      prev_stall = 0;
    end else begin
      chk("level", 32'(LEVEL), 32'(model_q.size()));
      if (model_q.size() >= CAP) chk("in_ready_full", 32'(IN_READY), 0);
      else if (model_q.size() < DEPTH) chk("in_ready_space", 32'(IN_READY), 1);
      chk("a1en_handshake", 32'(A1EN), 32'(IN_VALID & IN_READY));
      if (A1EN) begin
        chk("a1addr", 32'(A1ADDR), 32'(wr_total % DEPTH));
        chk("a1data", 32'(A1DATA), 32'(IN_DATA));
      end
      if (B1EN) begin
        chk("b1addr", 32'(B1ADDR), 32'(rd_total % DEPTH));
        rd_total++;
      end
      chk("raw_hazard", 32'(A1EN && B1EN && (A1ADDR == B1ADDR)), 0);
      if (prev_stall) begin
        chk("stall_valid", 32'(OUT_VALID), 1);
        chk("stall_data", 32'(OUT_DATA), 32'(prev_data));
      end
      if (OUT_VALID) begin
        chk("out_valid_vs_model", 32'(model_q.size() != 0), 1);
        if (model_q.size() != 0) chk("out_data", 32'(OUT_DATA), 32'(model_q[0]));
      end
      if (OUT_VALID && OUT_READY && model_q.size() != 0) void'(model_q.pop_front());
      if (IN_VALID && IN_READY) begin
        model_q.push_back(IN_DATA);
        wr_total++;
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 0;
    IN_VALID = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      OUT_READY = 1'b1;
      @(negedge CLK);
      if (LEVEL == '0 && !OUT_VALID) done = 1;
    end
    chk(name, 32'(done), 1);
    step();
    OUT_READY = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, acc, idle;
    bit first_seen, wrap_seen, ready_back, seen;
    logic [ABITS-1:0] prev_a;

    SCLR_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = '0;
    repeat (3) step();
    SCLR_N = 1'b1;
    step();

    // Single word: accepted cycle 0, read cycle 1, data cycle 2, visible cycle 3.
    IN_VALID = 1'b1; IN_DATA = 20'h12345;
    @(negedge CLK);
    chk("sw_a1en", 32'(A1EN), 1);
    chk("sw_a1addr", 32'(A1ADDR), 0);
    chk("sw_b1en_same_cycle", 32'(B1EN), 0);
    step(); IN_VALID = 1'b0;
    @(negedge CLK);
    chk("sw_b1en_next", 32'(B1EN), 1);
    chk("sw_b1addr", 32'(B1ADDR), 0);
    chk("sw_level1", 32'(LEVEL), 1);
    chk("sw_valid1", 32'(OUT_VALID), 0);
    step();
    @(negedge CLK);
    chk("sw_valid2", 32'(OUT_VALID), 0);
    chk("sw_level2", 32'(LEVEL), 1);
    step();
    @(negedge CLK);
    chk("sw_valid3", 32'(OUT_VALID), 1);
    chk("sw_data3", 32'(OUT_DATA), 32'h12345);
    chk("sw_level3", 32'(LEVEL), 1);
    step(); OUT_READY = 1'b1;
    @(negedge CLK);
    chk("sw_level4", 32'(LEVEL), 1);
    step(); OUT_READY = 1'b0;
    @(negedge CLK);
    chk("sw_level5", 32'(LEVEL), 0);
    chk("sw_valid5", 32'(OUT_VALID), 0);

    // Streaming 2000 words at full rate.
    sent = 0; got = 0; first_seen = 0; wrap_seen = 0; prev_a = '0;
    for (int i = 0; i < 2100 && got < 2000; i++) begin
      step();
      IN_VALID = (sent < 2000); IN_DATA = 20'(sent); OUT_READY = 1'b1;
      @(negedge CLK);
      if (IN_VALID && IN_READY) begin
        if (sent > 0 && prev_a == 10'd1023 && A1ADDR == 10'd0) wrap_seen = 1;
        prev_a = A1ADDR;
        sent++;
      end
      if (first_seen && got < 2000) chk("stream_gap", 32'(OUT_VALID), 1);
      if (OUT_VALID) begin
        first_seen = 1;
        got++;
      end
    end
    chk("stream_count", 32'(got), 2000);
    chk("stream_wrap", 32'(wrap_seen), 1);
    drain("stream_drain", 20);

    // Hazard at a non-zero address: write pointer is now (1 + 2000) mod 1024 = 977.
    step(); IN_VALID = 1'b1; IN_DATA = 20'($urandom);
    @(negedge CLK);
    chk("haz_a1addr", 32'(A1ADDR), 977);
    chk("haz_b1en_t", 32'(B1EN), 0);
    step(); IN_VALID = 1'b0;
    @(negedge CLK);
    chk("haz_b1en_t1", 32'(B1EN), 1);
    chk("haz_b1addr", 32'(B1ADDR), 977);
    drain("haz_drain", 20);

    // Fill to full with the consumer stalled.
    acc = 0; idle = 0;
    for (int i = 0; i < 1200 && idle < 3; i++) begin
      step();
      IN_VALID = 1'b1; IN_DATA = 20'($urandom); OUT_READY = 1'b0;
      @(negedge CLK);
      if (IN_READY) acc++; else idle++;
    end
    chk("fill_count", 32'(acc), 1026);
    chk("fill_level", 32'(LEVEL), 1026);
    chk("full_no_write", 32'(A1EN), 0);
    step(); OUT_READY = 1'b1;
    @(negedge CLK);
    chk("full_no_write_through", 32'(IN_READY), 0);
    ready_back = 0;
    for (int i = 0; i < 2 && !ready_back; i++) begin
      step(); OUT_READY = 1'b0; IN_VALID = 1'b0;
      @(negedge CLK);
      if (IN_READY) ready_back = 1;
    end
    chk("ready_after_pop", 32'(ready_back), 1);
    drain("fill_drain", 1200);

    // Random traffic with 30% consumer acceptance.
    for (int i = 0; i < 3000; i++) begin
      step();
      IN_VALID  = 1'($urandom_range(0, 1));
      IN_DATA   = 20'($urandom);
      OUT_READY = ($urandom_range(0, 9) < 3);
    end
    drain("rand_drain", 1200);

    // Reset with five words held and one read in flight.
    for (int i = 0; i < 6; i++) begin
      step(); IN_VALID = 1'b1; IN_DATA = 20'($urandom); OUT_READY = 1'b0;
    end
    step(); IN_VALID = 1'b0;
    repeat (4) step();
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("mid_issue_on_pop", 32'(B1EN), 1);
    chk("mid_level_pre", 32'(LEVEL), 6);
    step(); OUT_READY = 1'b0; SCLR_N = 1'b0;
    @(negedge CLK);
    chk("mid_rst_level", 32'(LEVEL), 0);
    step(); SCLR_N = 1'b1;
    @(negedge CLK);
    chk("mid_post_valid", 32'(OUT_VALID), 0);
    chk("mid_post_level", 32'(LEVEL), 0);
    chk("mid_post_ready", 32'(IN_READY), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge CLK);
      chk("mid_no_spurious", 32'(OUT_VALID), 0);
    end
    step(); IN_VALID = 1'b1; IN_DATA = 20'hABCDE;
    step(); IN_VALID = 1'b0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge CLK);
      if (OUT_VALID) begin
        seen = 1;
        chk("mid_readback", 32'(OUT_DATA), 32'hABCDE);
      end else step();
    end
    chk("mid_readback_seen", 32'(seen), 1);
    drain("mid_drain", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
